// File: rtl/decode_pkg_r32i.sv
// Shared opcode, ALU and branch codes plus the decoded bundle type for the RV32I decode stage.
// DECODE_SYSTEM_EN adds the Ecall/Ebreak fields to the bundle.
package decode_pkg_r32i;

  localparam logic [6:0] OP_LOAD     = 7'b000_0011;
  localparam logic [6:0] OP_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OP_OPPI     = 7'b001_0011;
  localparam logic [6:0] OP_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OP_STORE    = 7'b010_0011;
  localparam logic [6:0] OP_OPPR     = 7'b011_0011;
  localparam logic [6:0] OP_LUI      = 7'b011_0111;
  localparam logic [6:0] OP_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OP_JALR     = 7'b110_0111;
  localparam logic [6:0] OP_JAL      = 7'b110_1111;
  localparam logic [6:0] OP_SYSTEM   = 7'b111_0011;

  // Register ALU ops use {ins[30], funct3}; only the two fixed codes are named.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_CPY = 4'b1111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        link_write;
    logic        test_branch;
    logic        always_branch;
    logic        use_imm;
    logic        use_pc;
    logic [2:0]  branch_type;
    logic [3:0]  alu_code;
    logic [31:0] imm;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        illegal;
`ifdef DECODE_SYSTEM_EN
    logic        ecall;
    logic        ebreak;
`endif
  } decoded_t;

endpackage

// File: rtl/decode_comb_r32i.sv
// Purely combinational RV32I instruction decoder: raw word -> decoded_t.
// DECODE_SYSTEM_EN makes FENCE, ECALL and EBREAK legal.
module decode_comb_r32i
  import decode_pkg_r32i::*;
(
  input  logic [31:0] i_ins,
  output decoded_t    o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  decoded_t    w_dec;

  assign w_opcode = i_ins[6:0];
  assign w_funct3 = i_ins[14:12];
  assign w_funct7 = i_ins[31:25];

  assign w_imm_i = {{20{i_ins[31]}}, i_ins[31:20]};
  assign w_imm_s = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
  assign w_imm_b = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
  assign w_imm_u = {i_ins[31:12], 12'h000};
  assign w_imm_j = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};

  // Per-opcode field selection and legality, then enable suppression.
  always_comb begin
    w_dec     = '0;
    w_dec.rs1 = i_ins[19:15];
    w_dec.rs2 = i_ins[24:20];
    w_dec.rd  = i_ins[11:7];
    case (w_opcode)
      OP_OPPR: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_code  = {i_ins[30], w_funct3};
        w_dec.illegal   = ~((w_funct7 == 7'h00) ||
                            ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5))));
      end
      OP_OPPI: begin
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.alu_code  = {(w_funct3 == 3'd5) & i_ins[30], w_funct3};
        w_dec.illegal   = ((w_funct3 == 3'd1) && (w_funct7 != 7'h00)) ||
                          ((w_funct3 == 3'd5) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20));
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.alu_code  = ALU_CPY;
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.use_pc    = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.alu_code  = ALU_ADD;
      end
      OP_JAL: begin
        w_dec.reg_write     = 1'b1;
        w_dec.link_write    = 1'b1;
        w_dec.always_branch = 1'b1;
        w_dec.use_imm       = 1'b1;
        w_dec.imm           = w_imm_j;
        w_dec.alu_code      = ALU_CPY;
      end
      OP_JALR: begin
        w_dec.reg_write     = 1'b1;
        w_dec.link_write    = 1'b1;
        w_dec.always_branch = 1'b1;
        w_dec.use_imm       = 1'b1;
        w_dec.imm           = w_imm_i;
        w_dec.alu_code      = ALU_ADD;
        w_dec.illegal       = (w_funct3 != 3'd0);
      end
      OP_BRANCH: begin
        w_dec.test_branch = 1'b1;
        w_dec.use_imm     = 1'b1;
        w_dec.use_pc      = 1'b1;
        w_dec.imm         = w_imm_b;
        w_dec.alu_code    = ALU_ADD;
        w_dec.branch_type = w_funct3;
        case (w_funct3)
          BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU: w_dec.illegal = 1'b0;
          default:                                    w_dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_dec.mem_read  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.alu_code  = ALU_ADD;
        w_dec.mem_size  = w_funct3;
        w_dec.illegal   = (w_funct3 == 3'd3) || (w_funct3 >= 3'd6);
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.imm       = w_imm_s;
        w_dec.alu_code  = ALU_ADD;
        w_dec.mem_size  = w_funct3;
        w_dec.illegal   = (w_funct3 > 3'd2);
      end
`ifdef DECODE_SYSTEM_EN
      OP_MISC_MEM: begin
        w_dec.illegal = 1'b0;
      end
      OP_SYSTEM: begin
        w_dec.ecall   = (i_ins == INS_ECALL);
        w_dec.ebreak  = (i_ins == INS_EBREAK);
        w_dec.illegal = ~(w_dec.ecall | w_dec.ebreak);
      end
`endif
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.reg_write     = w_dec.reg_write & ~w_dec.illegal & (w_dec.rd != 5'd0);
    w_dec.mem_read      = w_dec.mem_read & ~w_dec.illegal;
    w_dec.mem_write     = w_dec.mem_write & ~w_dec.illegal;
    w_dec.test_branch   = w_dec.test_branch & ~w_dec.illegal;
    w_dec.always_branch = w_dec.always_branch & ~w_dec.illegal;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage_r32i.sv
// RV32I decode stage: decoder feeding a 2-entry skid buffer with valid/ready on both sides and flush.
// DECODE_SYSTEM_EN adds the o_ecall/o_ebreak outputs.
module decode_stage_r32i
  import decode_pkg_r32i::*;
#(
  parameter int dataW = 32,
  parameter int pcW   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_ins,
  input  logic [pcW-1:0]   i_in_pc,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [pcW-1:0]   o_out_pc,
  output logic [4:0]       o_reg_data1,
  output logic [4:0]       o_reg_data2,
  output logic [4:0]       o_reg_write_addr,
  output logic             o_reg_write_control,
  output logic             o_link_addr_write,
  output logic             o_test_branch,
  output logic             o_always_branch,
  output logic             o_use_imm,
  output logic             o_use_pc,
  output logic [2:0]       o_branch_type,
  output logic [3:0]       o_alu_code,
  output logic [dataW-1:0] o_imm_out,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [2:0]       o_mem_size,
`ifdef DECODE_SYSTEM_EN
  output logic             o_ecall,
  output logic             o_ebreak,
`endif
  output logic             o_illegal
);

  decoded_t       w_dec;
  decoded_t       r_main;
  decoded_t       r_skid;
  logic [pcW-1:0] r_main_pc;
  logic [pcW-1:0] r_skid_pc;
  logic           r_main_valid;
  logic           r_skid_valid;
  logic           w_accept;
  logic           w_drain;

  decode_comb_r32i u_decode (
    .i_ins (i_in_ins),
    .o_dec (w_dec)
  );

  // Ready depends only on the skid register, so there is no path from i_out_ready.
  assign w_accept = i_in_valid & ~r_skid_valid;
  assign w_drain  = r_main_valid & i_out_ready;

  // Skid buffer: main refills from skid first to keep order, else from the decoder.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
      r_main_pc    <= '0;
      r_skid_pc    <= '0;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_pc    <= r_skid_pc;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_dec;
        r_main_pc    <= i_in_pc;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_pc    <= i_in_pc;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_in_ready          = ~r_skid_valid;
  assign o_out_valid         = r_main_valid;
  assign o_out_pc            = r_main_pc;
  assign o_reg_data1         = r_main.rs1;
  assign o_reg_data2         = r_main.rs2;
  assign o_reg_write_addr    = r_main.rd;
  assign o_reg_write_control = r_main.reg_write;
  assign o_link_addr_write   = r_main.link_write;
  assign o_test_branch       = r_main.test_branch;
  assign o_always_branch     = r_main.always_branch;
  assign o_use_imm           = r_main.use_imm;
  assign o_use_pc            = r_main.use_pc;
  assign o_branch_type       = r_main.branch_type;
  assign o_alu_code          = r_main.alu_code;
  assign o_imm_out           = dataW'($signed(r_main.imm));
  assign o_mem_read          = r_main.mem_read;
  assign o_mem_write         = r_main.mem_write;
  assign o_mem_size          = r_main.mem_size;
  assign o_illegal           = r_main.illegal;
`ifdef DECODE_SYSTEM_EN
  assign o_ecall             = r_main.ecall;
  assign o_ebreak            = r_main.ebreak;
`endif

endmodule

// File: tb/tb_decode_stage_r32i.sv
// Bench for decode_stage_r32i: queue-based reference model checked every cycle plus directed literal checks.
module tb_decode_stage_r32i;
  import decode_pkg_r32i::ALU_CPY;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] ins, pc;
  logic        o_in_ready, o_out_valid;
  logic [31:0] o_out_pc, o_imm_out;
  logic [4:0]  o_reg_data1, o_reg_data2, o_reg_write_addr;
  logic        o_reg_write_control, o_link_addr_write, o_test_branch, o_always_branch;
  logic        o_use_imm, o_use_pc, o_mem_read, o_mem_write, o_illegal;
  logic [2:0]  o_branch_type, o_mem_size;
  logic [3:0]  o_alu_code;
`ifdef DECODE_SYSTEM_EN
  logic        o_ecall, o_ebreak;
`endif

  always #5 clk = ~clk;

  decode_stage_r32i dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_in_ins(ins), .i_in_pc(pc), .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_out_pc(o_out_pc), .o_reg_data1(o_reg_data1), .o_reg_data2(o_reg_data2),
    .o_reg_write_addr(o_reg_write_addr), .o_reg_write_control(o_reg_write_control),
    .o_link_addr_write(o_link_addr_write), .o_test_branch(o_test_branch),
    .o_always_branch(o_always_branch), .o_use_imm(o_use_imm), .o_use_pc(o_use_pc),
    .o_branch_type(o_branch_type), .o_alu_code(o_alu_code), .o_imm_out(o_imm_out),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_size(o_mem_size),
`ifdef DECODE_SYSTEM_EN
    .o_ecall(o_ecall), .o_ebreak(o_ebreak),
`endif
    .o_illegal(o_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, link, tb, ab, ui, up;
    logic [2:0]  bt;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        mr, mw;
    logic [2:0]  ms;
    logic        ill, ec, eb;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  exp_t        q[$];
  logic [31:0] drained[$];
  exp_t        e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference decode: field extraction by integer arithmetic on the instruction word.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a);
    exp_t r;
    int si, top, iimm, simm, bimm, jimm;
    logic [6:0] op, f7;
    logic [2:0] f3;
    r = '0;
    si = w;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    iimm = si >>> 20;
    top = si >>> 25;
    simm = top * 32 + int'(w[11:7]);
    top = si >>> 31;
    bimm = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    jimm = top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    r.pc = a; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    case (op)
      7'h33: begin r.rw = 1; r.alu = {w[30], f3};
               r.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))); end
      7'h13: begin r.rw = 1; r.ui = 1; r.imm = iimm;
               r.alu = (f3 == 3'd5) ? {w[30], f3} : {1'b0, f3};
               r.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20); end
      7'h37: begin r.rw = 1; r.ui = 1; r.imm = w & 32'hFFFFF000; r.alu = ALU_CPY; end
      7'h17: begin r.rw = 1; r.ui = 1; r.up = 1; r.imm = w & 32'hFFFFF000; r.alu = 4'd0; end
      7'h6F: begin r.rw = 1; r.link = 1; r.ab = 1; r.ui = 1; r.imm = jimm; r.alu = ALU_CPY; end
      7'h67: begin r.rw = 1; r.link = 1; r.ab = 1; r.ui = 1; r.imm = iimm; r.ill = (f3 != 3'd0); end
      7'h63: begin r.tb = 1; r.ui = 1; r.up = 1; r.imm = bimm; r.bt = f3;
               r.ill = (f3 == 3'd2 || f3 == 3'd3); end
      7'h03: begin r.mr = 1; r.rw = 1; r.ui = 1; r.imm = iimm; r.ms = f3;
               r.ill = (f3 == 3'd3 || f3 >= 3'd6); end
      7'h23: begin r.mw = 1; r.ui = 1; r.imm = simm; r.ms = f3; r.ill = (f3 > 3'd2); end
`ifdef DECODE_SYSTEM_EN
      7'h0F: r.ill = 1'b0;
      7'h73: begin r.ec = (w == 32'h00000073); r.eb = (w == 32'h00100073); r.ill = !(r.ec || r.eb); end
`endif
      default: r.ill = 1'b1;
    endcase
    if (r.ill || r.rd == 5'd0) r.rw = 1'b0;
    if (r.ill) begin r.mr = 0; r.mw = 0; r.tb = 0; r.ab = 0; end
    return r;
  endfunction

  function automatic exp_t dut_now();
    exp_t r;
    r.pc = o_out_pc; r.rs1 = o_reg_data1; r.rs2 = o_reg_data2; r.rd = o_reg_write_addr;
    r.rw = o_reg_write_control; r.link = o_link_addr_write; r.tb = o_test_branch;
    r.ab = o_always_branch; r.ui = o_use_imm; r.up = o_use_pc; r.bt = o_branch_type;
    r.alu = o_alu_code; r.imm = o_imm_out; r.mr = o_mem_read; r.mw = o_mem_write;
    r.ms = o_mem_size; r.ill = o_illegal;
`ifdef DECODE_SYSTEM_EN
    r.ec = o_ecall; r.eb = o_ebreak;
`else
    r.ec = 1'b0; r.eb = 1'b0;
`endif
    return r;
  endfunction

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", o_in_ready, q.size() < 2);
      check("out_valid", o_out_valid, q.size() > 0);
      if (q.size() > 0 && o_out_valid) check("bundle", dut_now(), q[0]);
      if (rst || flush) begin
        q.delete();
      end else begin
        logic acc;
        acc = in_valid && (q.size() < 2);
        if (q.size() > 0 && out_ready) begin
          drained.push_back(q[0].pc);
          void'(q.pop_front());
        end
        if (acc) q.push_back(model(ins, pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] w, input logic [31:0] a);
    in_valid = 1'b1; ins = w; pc = a;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  localparam int NV = 23;
  logic [31:0] vec [NV] = '{
    32'h123452B7, 32'h00001317, 32'h008000EF, 32'h000080E7, 32'h000090E7, 32'hFE000EE3,
    32'hFE002EE3, 32'h00209463, 32'hFFC0A383, 32'h0000C403, 32'h0000B403, 32'hFE20AE23,
    32'h0020B023, 32'h4020D233, 32'h40209233, 32'h00309093, 32'h4030D093, 32'h8030D093,
    32'h40008093, 32'h00500013, 32'h0FF0000F, 32'h00100073, 32'h00500090};

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; ins = 0; pc = 0;
    step();
    chk_en = 1'b1;
    step();
    check("reset_valid", o_out_valid, 1'b0);
    check("reset_ready", o_in_ready, 1'b1);
    check("reset_zero", dut_now(), '0);
    rst = 0;

    // Pin the reference model to hand-computed values.
    e = model(32'hFE000EE3, 0); check("model_b_imm", e.imm, 32'hFFFFFFFC);
    e = model(32'h008000EF, 0); check("model_j", {e.imm, e.link, e.ab, e.rw}, {32'd8, 3'b111});
    e = model(32'hFE20AE23, 0); check("model_s", {e.imm, e.mw, e.ms}, {32'hFFFFFFFC, 1'b1, 3'd2});
    e = model(32'h123452B7, 0); check("model_u", {e.imm, e.rd}, {32'h12345000, 5'd5});
    e = model(32'h4020D233, 0); check("model_sra", {e.alu, e.ill}, {4'hD, 1'b0});
    e = model(32'h40008093, 0); check("model_addi30", {e.alu, e.imm}, {4'h0, 32'h400});

    out_ready = 1;
    send1(32'h00500093, 32'h100);
    check("addi", {o_out_valid, o_alu_code, o_imm_out, o_reg_write_addr, o_use_imm, o_reg_write_control},
          {1'b1, 4'd0, 32'd5, 5'd1, 1'b1, 1'b1});
    send1(32'h0020A423, 32'h104);
    check("sw", {o_out_valid, o_mem_write, o_mem_size, o_imm_out, o_reg_data1, o_reg_data2, o_reg_write_control},
          {1'b1, 1'b1, 3'd2, 32'd8, 5'd1, 5'd2, 1'b0});
    step();

    // Backpressure: two accepted, third held off, then all three drain in order.
    out_ready = 0; drained.delete();
    in_valid = 1; ins = 32'h002081B3; pc = 32'h200; step();
    ins = 32'h40208233; pc = 32'h204; step();
    check("third_blocked", o_in_ready, 1'b0);
    ins = 32'hFFF0C293; pc = 32'h208; step();
    check("still_blocked", o_in_ready, 1'b0);
    out_ready = 1; step();
    step();
    in_valid = 0; step(); step();
    check("order_count", drained.size(), 3);
    if (drained.size() == 3)
      check("order_pcs", {drained[0], drained[1], drained[2]}, {32'h200, 32'h204, 32'h208});

    // Flush with one and with two entries buffered, while offering a new word.
    for (int n = 1; n <= 2; n++) begin
      out_ready = 0;
      for (int k = 0; k < n; k++) begin
        in_valid = 1; ins = 32'h00100093; pc = 32'h300 + 4 * k; step();
      end
      flush = 1; in_valid = 1; ins = 32'h00700313; pc = 32'h3F0; step();
      flush = 0; in_valid = 0; drained.delete();
      check("flush_valid", o_out_valid, 1'b0);
      check("flush_ready", o_in_ready, 1'b1);
      out_ready = 1; repeat (4) step();
      check("flush_nothing_out", drained.size(), 0);
    end

    // Illegal encodings and system instructions.
    out_ready = 1;
    send1(32'hFFFFFFFF, 32'h400);
    check("ill_ones", {o_illegal, o_reg_write_control, o_mem_read, o_mem_write, o_test_branch, o_always_branch},
          6'b100000);
    send1(32'h02208033, 32'h404);
    check("ill_funct7", {o_illegal, o_reg_write_control, o_mem_read, o_mem_write, o_test_branch, o_always_branch},
          6'b100000);
    send1(32'h00000073, 32'h408);
`ifdef DECODE_SYSTEM_EN
    check("ecall", {o_ecall, o_illegal}, 2'b10);
`else
    check("ecall_illegal", o_illegal, 1'b1);
`endif
    step();

    // Directed vector stream under varying backpressure; the model checks every bundle.
    for (int i = 0; i < NV; i++) begin
      logic was_ready;
      int   tries;
      in_valid = 1; ins = vec[i]; pc = 32'h1000 + 4 * i;
      tries = 0;
      do begin
        out_ready = ((i + tries) % 3) != 1;
        was_ready = o_in_ready;
        step();
        tries++;
      end while (!was_ready && tries < 10);
      if (!was_ready) check("accept_timeout", tries, 0);
    end
    in_valid = 0; out_ready = 1;
    repeat (4) step();
    check("drain_all", q.size(), 0);

    // Reset with both entries full.
    out_ready = 0;
    send1(32'h00500093, 32'h500);
    send1(32'h0020A423, 32'h504);
    check("full_before_reset", o_in_ready, 1'b0);
    rst = 1; in_valid = 1; ins = 32'h00700313; step();
    rst = 0; in_valid = 0;
    check("rst_full_valid", o_out_valid, 1'b0);
    check("rst_full_ready", o_in_ready, 1'b1);
    check("rst_full_zero", dut_now(), '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_r32i.md
Name: decode_stage_r32i

Overview:
- Registered, flow-controlled RV32I decode stage between fetch and execute.
- Decodes the full RV32I base set, including LOAD/STORE memory control, illegal-instruction detection and PC pass-through.
- Holds results in a 2-entry skid buffer with valid/ready handshakes on both sides and a flush input for taken branches.

Parameters:
- dataW, 32, datapath/immediate width (>=32; immediates sign-extended to dataW).
- pcW, 32, width of carried program address.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- Flush  in  1  discard all buffered and in-flight instructions
- InValid  in  1  fetch presents instruction
- InReady  out  1  stage can accept
- InIns  in  32  raw instruction
- InPC  in  pcW  instruction address
- OutValid  out  1  decoded bundle valid
- OutReady  in  1  execute accepts bundle
- OutPC  out  pcW  carried address
- RegData1, RegData2, RegWriteAddr  out  5 each  register addresses
- RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch, UseImm, UsePC  out  1 each  control flags
- BranchType  out  3  funct3 of branch
- ALUCode  out  4  ALU operation
- ImmOut  out  dataW  decoded immediate
- MemRead, MemWrite  out  1 each  load/store
- MemSize  out  3  funct3 of load/store (size + unsigned)
- Illegal  out  1  instruction not decodable

Behaviour:
- Reset (sync, high): both skid entries invalid; OutValid=0; all bundle outputs 0; InReady=1 the cycle after reset deasserts.
- Transfer in when InValid&&InReady; transfer out when OutValid&&OutReady.
- Latency: accepted instruction appears on OutValid the next cycle if the main entry is empty or draining.
- Skid: InReady is a register (~SkidValid), no combinational path from OutReady.
  - Accept while main is full and not draining -> word goes to the skid entry.
  - Next drain promotes skid to main.
  - Order always preserved. Simultaneous accept and drain with skid empty -> main reloads directly.
- Outputs are only meaningful while OutValid=1; bundle held stable while OutValid&&!OutReady.
- Decode per opcode matches the established ALU/branch code tables:
  - OPPI/OPPR: ALUCode = {ins[30],funct3}; ins[30] used for OPPI only when funct3==5.
  - LUI: CPY. AUIPC: ADD with UsePC.
  - JAL: CPY, J-immediate. JALR: ADD, I-immediate.
  - BRANCH: ADD, UsePC, B-immediate, TestBranch.
  - LOAD: MemRead, I-immediate, ADD, UseImm, RegWriteControl.
  - STORE: MemWrite, S-immediate, ADD, UseImm.
- RegWriteControl forced 0 when rd==0.
- Illegal=1 for any of:
  - unknown opcode, or ins[1:0]!=2'b11;
  - OPPR funct7 not 0x00/0x20 (0x20 only for funct3 0 or 5);
  - OPPI shift with bad funct7;
  - JALR funct3!=0; BRANCH funct3 2/3; LOAD funct3 3/6/7; STORE funct3>2.
- Illegal bundles still flow; RegWriteControl, MemRead, MemWrite, TestBranch and AlwaysBranch are forced 0.
- Flush: next cycle both entries invalid, OutValid=0, InReady=1. An input accepted in the Flush cycle is dropped. Flush has priority over accept and drain. Flush during Reset: Reset wins (same result).

Optional Feature:
- Macro: DECODE_SYSTEM_EN.
- Defined: MISC-MEM (0x0F, FENCE) decodes as legal no-op. SYSTEM (0x73) ECALL (0x00000073) and EBREAK (0x00100073) decode as legal, with extra outputs Ecall and Ebreak (1 bit each) asserted.
- Undefined: both opcodes flag Illegal; Ecall/Ebreak ports absent.

Decomposition:
- Package decode_pkg_r32i holds:
  - opcode, ALU code and branch code constants;
  - typedef struct packed decoded_t containing every bundle field, so the skid entries store one decoded_t each.
- Sub-module decode_comb_r32i: purely combinational InIns -> decoded_t, including sign extension and illegal checks.
- The stage module holds only the handshake, skid buffer and flush logic.

Test Plan:
- ADDI x1,x0,5 (0x00500093), OutReady=1 -> next cycle OutValid=1, ALUCode=0, ImmOut=5, RegWriteAddr=1, UseImm=1, RegWriteControl=1.
- SW x2,8(x1) (0x0020A423) -> MemWrite=1, MemSize=2, ImmOut=8, RegData1=1, RegData2=2, RegWriteControl=0.
- OutReady=0, push 3 back-to-back instructions:
  - two accepted, InReady=0 on the 3rd;
  - then OutReady=1 -> all three emerge in order, no loss or duplication.
- Two instructions buffered, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, no buffered or new instruction ever appears.
- 0xFFFFFFFF and ADD-with-funct7 0x01 (0x02208033) -> Illegal=1, all write/branch/mem enables 0; with DECODE_SYSTEM_EN, 0x00000073 -> Ecall=1, Illegal=0.
- Reset asserted with both entries full -> next cycle OutValid=0, all outputs 0, InReady=1.
